// File: rtl/encode_pack_if.sv
// encode_pack_if: token input, packed-byte output and stall signals of encode_pack.
//
// Handshake rules:
//   tok_valid/tok_ack : the source holds tok_type/tok_lit/tok_off/tok_len stable
//                       while tok_valid is high, until a cycle in which tok_ack
//                       is high; the token is consumed at that cycle's rising edge.
//                       tok_ack is a single-cycle pulse, exactly once per token.
//   out_valid         : single-cycle strobe; out_data is a new byte in every cycle
//                       out_valid is high. A byte is only launched in a cycle with
//                       fo_full low, so out_valid follows a cycle of fo_full = 0.
//   out_done          : level, high while the stream is complete and flushed.
interface encode_pack_if;
    logic        ce;
    logic        tok_valid;
    logic [1:0]  tok_type;
    logic [7:0]  tok_lit;
    logic [10:0] tok_off;
    logic [7:0]  tok_len;
    logic        tok_ack;
    logic        fo_full;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_done;
    logic [2:0]  dbg_state;

    modport master (
        output ce, tok_valid, tok_type, tok_lit, tok_off, tok_len, fo_full,
        input  tok_ack, out_data, out_valid, out_done, dbg_state
    );

    modport slave (
        input  ce, tok_valid, tok_type, tok_lit, tok_off, tok_len, fo_full,
        output tok_ack, out_data, out_valid, out_done, dbg_state
    );
endinterface

// File: rtl/encode_pack.sv
// encode_pack: variable-length token encoder packing code bits MSB-first into bytes.
// Bits collect left-justified in a 24-bit accumulator; fields are appended while at
// most 11 bits are held, and a byte is launched whenever 8+ bits are held and the
// output FIFO has room. Append and launch may happen in the same cycle.
module encode_pack (
    input  logic         clk,
    input  logic         rst_n,
    encode_pack_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TOK   = 3'd1,
        S_LEN   = 3'd2,
        S_EXT   = 3'd3,
        S_END   = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [23:0] r_acc;
    logic [4:0]  r_fcnt;
    logic [7:0]  r_rem;
    logic [7:0]  r_out_data;
    logic        r_out_valid;

    logic        w_room;
    logic        w_room_end;
    logic        w_app;
    logic        w_ack;
    logic        w_load_rem;
    logic        w_dec_rem;
    logic [15:0] w_fld;
    logic [4:0]  w_wid;
    logic [4:0]  w_end_sum;
    logic [2:0]  w_pad;
    logic [7:0]  w_len_m2;
    logic [7:0]  w_len_m5;
    logic        w_emit;
    logic [23:0] w_acc_sh;
    logic [4:0]  w_fcnt_sh;
    logic [23:0] w_fld_lj;
    logic [23:0] w_acc_nx;
    logic [4:0]  w_fcnt_nx;

    assign w_room     = (r_fcnt <= 5'd11);
    assign w_room_end = (r_fcnt <= 5'd8);
    // End marker is padded so that held bits plus marker end on a byte boundary.
    assign w_end_sum  = r_fcnt + 5'd9;
    assign w_pad      = 3'd0 - w_end_sum[2:0];
    assign w_len_m2   = bus.tok_len - 8'd2;
    assign w_len_m5   = bus.tok_len - 8'd5;

    // Next-state and field selection; the field is right-justified in w_fld.
    always_comb begin
        w_state_nx = r_state;
        w_app      = 1'b0;
        w_ack      = 1'b0;
        w_load_rem = 1'b0;
        w_dec_rem  = 1'b0;
        w_fld      = 16'd0;
        w_wid      = 5'd0;
        case (r_state)
            S_IDLE: begin
                if (bus.ce) w_state_nx = S_TOK;
            end
            S_TOK: begin
                if (bus.tok_valid && w_room) begin
                    case (bus.tok_type)
                        2'b00: begin
                            w_app = 1'b1;
                            w_ack = 1'b1;
                            w_fld = {7'd0, 1'b0, bus.tok_lit};
                            w_wid = 5'd9;
                        end
                        2'b01: begin
                            w_app      = 1'b1;
                            w_state_nx = S_LEN;
                            if (bus.tok_off < 11'd128) begin
                                w_fld = {7'd0, 2'b11, bus.tok_off[6:0]};
                                w_wid = 5'd9;
                            end else begin
                                w_fld = {3'd0, 2'b10, bus.tok_off};
                                w_wid = 5'd13;
                            end
                        end
                        default: w_state_nx = S_END;
                    endcase
                end
            end
            S_LEN: begin
                if (w_room) begin
                    w_app = 1'b1;
                    if (bus.tok_len <= 8'd4) begin
                        w_fld      = {14'd0, w_len_m2[1:0]};
                        w_wid      = 5'd2;
                        w_ack      = 1'b1;
                        w_state_nx = S_TOK;
                    end else if (bus.tok_len <= 8'd7) begin
                        w_fld      = {12'd0, 2'b11, w_len_m5[1:0]};
                        w_wid      = 5'd4;
                        w_ack      = 1'b1;
                        w_state_nx = S_TOK;
                    end else begin
                        w_fld      = 16'h000F;
                        w_wid      = 5'd4;
                        w_load_rem = 1'b1;
                        w_state_nx = S_EXT;
                    end
                end
            end
            S_EXT: begin
                if (w_room) begin
                    w_app = 1'b1;
                    w_wid = 5'd4;
                    if (r_rem >= 8'd15) begin
                        w_fld     = 16'h000F;
                        w_dec_rem = 1'b1;
                    end else begin
                        w_fld      = {12'd0, r_rem[3:0]};
                        w_ack      = 1'b1;
                        w_state_nx = S_TOK;
                    end
                end
            end
            S_END: begin
                if (w_room_end) begin
                    w_app      = 1'b1;
                    w_ack      = 1'b1;
                    w_fld      = {7'd0, 9'h180} << w_pad;
                    w_wid      = 5'd9 + {2'b00, w_pad};
                    w_state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_fcnt == 5'd0) w_state_nx = S_DONE;
            end
            S_DONE: begin
                if (!bus.ce) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Accumulator update: launch a byte first, then place the field right after the remaining bits.
    always_comb begin
        w_emit    = (r_fcnt >= 5'd8) && !bus.fo_full;
        w_acc_sh  = w_emit ? {r_acc[15:0], 8'h00} : r_acc;
        w_fcnt_sh = w_emit ? (r_fcnt - 5'd8) : r_fcnt;
        w_fld_lj  = {w_fld, 8'h00} << (5'd16 - w_wid);
        w_acc_nx  = w_app ? (w_acc_sh | (w_fld_lj >> w_fcnt_sh)) : w_acc_sh;
        w_fcnt_nx = w_app ? (w_fcnt_sh + w_wid) : w_fcnt_sh;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // Datapath registers: accumulator, fill count, length remainder, output byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= 24'd0;
            r_fcnt      <= 5'd0;
            r_rem       <= 8'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_acc       <= w_acc_nx;
            r_fcnt      <= w_fcnt_nx;
            r_out_valid <= w_emit;
            if (w_emit)     r_out_data <= r_acc[23:16];
            if (w_load_rem) r_rem      <= bus.tok_len - 8'd8;
            else if (w_dec_rem) r_rem  <= r_rem - 8'd15;
        end
    end

    assign bus.tok_ack   = w_ack;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_done  = (r_state == S_DONE);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_encode_pack.sv
// tb_encode_pack: drives token streams into encode_pack and compares every output
// byte with a bit-queue reference encoder.
module tb_encode_pack;
    typedef struct {
        logic [1:0]  typ;
        logic [7:0]  lit;
        logic [10:0] off;
        logic [7:0]  len;
    } tok_t;

    logic clk;
    logic rst_n;
    encode_pack_if bus();

    encode_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         full_mode = 0;
    int         hold_ctr  = 0;
    int         tog_ctr   = 0;
    bit         mon_ignore = 0;
    logic [7:0] exp_q[$];
    tok_t       stream_q[$];
    bit         model_bits[$];

    // monitor-owned per-stream observations
    int  s_acks    = 0;
    int  s_ack_cyc = -1;
    int  s_val_cyc = -1;
    bit  prev_ce   = 0;
    bit  prev_full = 0;

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // fo_full pattern generator
    always @(posedge clk) begin
        #1;
        if (full_mode == 1) tog_ctr = tog_ctr + 1; else tog_ctr = 0;
        if (full_mode == 3) hold_ctr = hold_ctr + 1; else hold_ctr = 0;
        case (full_mode)
            1:       bus.fo_full = ((tog_ctr / 3) % 2) == 1;
            2:       bus.fo_full = ($urandom_range(0, 3) == 0);
            3:       bus.fo_full = (hold_ctr < 25);
            default: bus.fo_full = 1'b0;
        endcase
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && !mon_ignore) begin
            if (bus.ce && !prev_ce) begin
                s_acks    = 0;
                s_ack_cyc = -1;
                s_val_cyc = -1;
            end
            if (bus.tok_ack) begin
                if (s_acks == 0) s_ack_cyc = cyc;
                s_acks = s_acks + 1;
            end
            if (bus.out_valid) begin
                if (s_val_cyc < 0) s_val_cyc = cyc;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_byte: got %02h, required no byte", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        failures = failures + 1;
                        $display("FAIL out_data: got %02h required %02h (cycle %0d)", bus.out_data, e, cyc);
                    end
                end
                checks = checks + 1;
                if (prev_full) begin
                    failures = failures + 1;
                    $display("FAIL emit_while_full: out_valid=1 required 0 after fo_full=1 (cycle %0d)", cyc);
                end
            end
        end
        prev_ce   = bus.ce;
        prev_full = bus.fo_full;
    end

    task automatic check(input string name, input int got, input int req);
        checks = checks + 1;
        if (got != req) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // reference encoder: builds the code as a plain bit sequence, then cuts bytes
    function automatic void put(input int val, input int w);
        for (int i = w - 1; i >= 0; i--) model_bits.push_back(((val >> i) & 1) == 1);
    endfunction

    function automatic void model_stream();
        int r;
        bit stop;
        logic [7:0] b;
        model_bits.delete();
        stop = 0;
        foreach (stream_q[k]) begin
            if (!stop) begin
                if (stream_q[k].typ == 2'b00) begin
                    put(0, 1);
                    put(int'(stream_q[k].lit), 8);
                end else if (stream_q[k].typ == 2'b01) begin
                    if (stream_q[k].off < 128) begin
                        put(3, 2);
                        put(int'(stream_q[k].off) % 128, 7);
                    end else begin
                        put(2, 2);
                        put(int'(stream_q[k].off), 11);
                    end
                    if (stream_q[k].len <= 4) put(int'(stream_q[k].len) - 2, 2);
                    else if (stream_q[k].len <= 7) put(12 + int'(stream_q[k].len) - 5, 4);
                    else begin
                        put(15, 4);
                        r = int'(stream_q[k].len) - 8;
                        while (r >= 15) begin
                            put(15, 4);
                            r = r - 15;
                        end
                        put(r, 4);
                    end
                end else begin
                    put(9'h180, 9);
                    while ((model_bits.size() % 8) != 0) model_bits.push_back(1'b0);
                    stop = 1;
                end
            end
        end
        while (model_bits.size() >= 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], model_bits.pop_front()};
            exp_q.push_back(b);
        end
    endfunction

    // stream builders
    function automatic tok_t mk(input logic [1:0] typ, input int lit, input int off, input int len);
        tok_t t;
        t.typ = typ;
        t.lit = 8'(lit);
        t.off = 11'(off);
        t.len = 8'(len);
        return t;
    endfunction

    function automatic tok_t rand_tok();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 5) return mk(2'b00, $urandom_range(0, 255), 0, 0);
        return mk(2'b01, 0,
                  ($urandom_range(0, 1) == 1) ? $urandom_range(1, 127) : $urandom_range(128, 2047),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(8, 255) : $urandom_range(2, 7));
    endfunction

    // driver: offers each token until acknowledged, then waits for the stream to finish
    task automatic run_stream(input int mode, input bit gaps, input bit lat_check);
        bit got;
        int n;
        n = stream_q.size();
        model_stream();
        full_mode = mode;
        bus.ce = 1'b1;
        foreach (stream_q[k]) begin
            if (gaps) begin
                bus.tok_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.tok_valid = 1'b1;
            bus.tok_type  = stream_q[k].typ;
            bus.tok_lit   = stream_q[k].lit;
            bus.tok_off   = stream_q[k].off;
            bus.tok_len   = stream_q[k].len;
            got = 0;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                if (bus.tok_ack) got = 1;
                @(posedge clk);
                #1;
            end
            check("tok_ack_timeout", int'(got), 1);
        end
        bus.tok_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 600 && !got; c++) begin
            @(negedge clk);
            if (bus.out_done) got = 1;
        end
        check("out_done_reached", int'(got), 1);
        check("bytes_left", exp_q.size(), 0);
        check("tok_ack_count", s_acks, n);
        if (lat_check) check("literal_latency", s_val_cyc - s_ack_cyc, 2);
        exp_q.delete();
        @(posedge clk);
        #1;
        bus.ce    = 1'b0;
        full_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("out_done_fall", int'(bus.out_done), 0);
        stream_q.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.ce        = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_type  = 2'b00;
        bus.tok_lit   = 8'h00;
        bus.tok_off   = 11'd0;
        bus.tok_len   = 8'd0;
        bus.fo_full   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tok_ack", int'(bus.tok_ack), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_done", int'(bus.out_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // literal 0x41 then end: 20 E0 00, first byte two cycles after tok_ack
        stream_q.push_back(mk(2'b00, 8'h41, 0, 0));
        stream_q.push_back(mk(2'b10, 0, 0, 0));
        run_stream(0, 0, 1);

        // match off=1 len=2 then end: C0 98 00, two acks
        stream_q.push_back(mk(2'b01, 0, 1, 2));
        stream_q.push_back(mk(2'b10, 0, 0, 0));
        run_stream(0, 0, 0);

        // long offset, extended length (two 1111 extensions then 0000), reserved-type end
        stream_q.push_back(mk(2'b01, 0, 300, 23));
        stream_q.push_back(mk(2'b11, 0, 0, 0));
        run_stream(0, 0, 0);

        // ten literals with fo_full toggling every 3 cycles
        for (int i = 0; i < 10; i++) stream_q.push_back(mk(2'b00, $urandom_range(0, 255), 0, 0));
        stream_q.push_back(mk(2'b10, 0, 0, 0));
        run_stream(1, 0, 0);

        // boundary lengths and offsets
        stream_q.push_back(mk(2'b01, 0, 127, 4));
        stream_q.push_back(mk(2'b01, 0, 128, 5));
        stream_q.push_back(mk(2'b01, 0, 2047, 7));
        stream_q.push_back(mk(2'b01, 0, 1, 8));
        stream_q.push_back(mk(2'b01, 0, 2, 22));
        stream_q.push_back(mk(2'b01, 0, 3, 255));
        stream_q.push_back(mk(2'b10, 0, 0, 0));
        run_stream(3, 0, 0);

        // reset in the middle of a match, then a clean stream
        mon_ignore    = 1'b1;
        bus.ce        = 1'b1;
        bus.tok_valid = 1'b1;
        bus.tok_type  = 2'b01;
        bus.tok_off   = 11'd300;
        bus.tok_len   = 8'd200;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tok_ack", int'(bus.tok_ack), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_data", int'(bus.out_data), 0);
        check("midrst_out_done", int'(bus.out_done), 0);
        bus.tok_valid = 1'b0;
        bus.ce        = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        mon_ignore = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        stream_q.push_back(mk(2'b00, 8'hA5, 0, 0));
        stream_q.push_back(mk(2'b01, 0, 1000, 40));
        stream_q.push_back(mk(2'b10, 0, 0, 0));
        run_stream(0, 0, 1);

        // randomized streams
        for (int s = 0; s < 25; s++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) stream_q.push_back(rand_tok());
            stream_q.push_back(mk(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10, 0, 0, 0));
            run_stream($urandom_range(0, 3), ($urandom_range(0, 1) == 1), 0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/encode_pack.md
ENCODE_PACK -- requirements
Module: encode_pack

Interface
REQ-001 The block SHALL provide the following ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- ce  in  1  enable; 0->1 starts a stream, dropping to 0 in S_DONE returns to idle
- tok_valid  in  1  token present
- tok_type  in  2  token type: 00 literal, 01 match, 10 end, 11 reserved (treated as end)
- tok_lit  in  8  literal byte
- tok_off  in  11  match offset, 1..2047
- tok_len  in  8  match length, 2..255
- tok_ack  out  1  one-cycle pulse: token consumed
- fo_full  in  1  output FIFO full; no byte is emitted while high
- out_data  out  8  packed byte, MSB = earliest bit
- out_valid  out  1  out_data valid this cycle
- out_done  out  1  stream finished and fully flushed
REQ-002 Reset SHALL be asynchronous, active-low on rst_n, with a single clock clk; no other clock or reset is permitted.

Function
REQ-003 Bit order SHALL be MSB-first; the first code bit occupies bit 7 of the first byte.
REQ-004 Literal SHALL be coded as 0 followed by tok_lit[7:0] (9 bits).
REQ-005 Match offset SHALL be coded as:
- tok_off < 128: 11 + off[6:0] (9 bits)
- tok_off >= 128: 10 + off[10:0] (13 bits)
REQ-006 Match length SHALL be coded as:
- 2/3/4: 00/01/10
- 5/6/7: 1100/1101/1110
- >= 8: 1111; then r = len-8; while r >= 15, emit 1111 and subtract 15; then emit r as 4 bits.
REQ-007 End marker SHALL be 110000000 (9 bits), followed by zero pad bits to the next byte boundary.
REQ-008 The block SHALL use a 24-bit accumulator acc and a 5-bit fill count fcnt (0..24); valid bits are left-justified in acc.
REQ-009 A field of width w (at most 13) SHALL be appended only when fcnt <= 11.
REQ-010 When fcnt >= 8 and fo_full = 0, the block SHALL register out_data = acc[23:16] and out_valid = 1 for the next cycle, and shift acc left by 8.
REQ-011 Append and emit SHALL be allowed in the same cycle; the resulting fcnt = fcnt + w - 8.
REQ-012 The state machine SHALL have states S_IDLE, S_TOK, S_LEN, S_EXT, S_END, S_FLUSH, S_DONE, with these transitions:
- S_IDLE -> S_TOK when ce = 1.
- S_TOK, tok_valid, room: literal -> append 9 bits, tok_ack, stay; match -> append offset field, go to S_LEN; end -> go to S_END.
- S_LEN, room: append 2/4-bit length code; len <= 7 -> tok_ack, go to S_TOK; else load r = len-8, go to S_EXT.
- S_EXT, room: r >= 15 -> append 1111, r -= 15, stay; else append r, tok_ack, go to S_TOK.
- S_END, room: append marker plus pad to the byte boundary (total width at most 16, requires fcnt <= 8), tok_ack, go to S_FLUSH.
- S_FLUSH: when fcnt = 0 -> go to S_DONE.
- S_DONE: out_done = 1; ce = 0 -> go to S_IDLE.
REQ-013 tok_ack SHALL pulse exactly once per token, in the cycle its last field is appended; token inputs SHALL be sampled only in S_TOK and held by the source until tok_ack.
REQ-014 Latency SHALL be: a literal accepted into an empty accumulator produces its first byte on out_valid 2 cycles after tok_ack when fo_full = 0.
REQ-015 When fo_full is held high, emission SHALL stall; appends SHALL continue until fcnt > 11, and no bits may be lost or reordered.
REQ-016 tok_type 11 SHALL be treated as end.
REQ-017 Out-of-range tok_off or tok_len values are undefined, but SHALL NOT hang the state machine.
REQ-018 Sustained throughput SHALL be 8 bits per cycle at the output when fo_full = 0.

Reset
REQ-019 While rst_n = 0, the block SHALL hold: state = S_IDLE, acc = 0, fcnt = 0, r = 0, tok_ack = 0, out_valid = 0, out_data = 0x00, out_done = 0.
REQ-020 Reset assertion mid-stream SHALL discard all buffered bits; after deassertion, no partial byte is emitted.

Verification
REQ-021 Literal 0x41 then end, fo_full = 0 -> bytes 0x20, 0xE0, 0x00, then out_done = 1.
REQ-022 Match off = 1, len = 2, then end -> bytes 0xC0, 0x98, 0x00; tok_ack count = 2.
REQ-023 Match off = 300, len = 23 -> field sequence 10 00100101100, 1111, 1111, 0000; tok_ack only after the last 0000.
REQ-024 10 literals with fo_full toggling every 3 cycles -> byte stream identical to the fo_full = 0 run, and no out_valid while fo_full = 1.
REQ-025 rst_n pulsed low mid-match -> all outputs at reset values; a new stream after ce produces correct bytes with no residue.
REQ-026 ce low in S_DONE -> out_done falls and state returns to S_IDLE; a second stream encodes correctly.
